// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: DEPTH stages of {valid, ctrl, data} with stall, flush and occupancy.
// Optional perf counters (stall cycles, killed entries) are built only when PIPE_REG_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              clr,
    input  logic              validD,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [DATA_W-1:0] dataD,
    output logic              validE,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [DATA_W-1:0] dataE,
    output logic [2:0]        occ,
    output logic [CNT_W-1:0]  stallCnt,
    output logic [CNT_W-1:0]  killCnt
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;

    // Priority clr > stall > advance; a bubble entering stage 0 carries ctrl=0.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = '0;
            ctrl_d  = '0;
            data_d  = '0;
        end else if (!stall) begin
            valid_d[0] = validD;
            ctrl_d[0]  = validD ? ctrlD : '0;
            data_d[0]  = dataD;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + 3'(valid_q[k]);
        end
    end

    assign validE = valid_q[DEPTH-1];
    assign ctrlE  = ctrl_q[DEPTH-1];
    assign dataE  = data_q[DEPTH-1];

`ifdef PIPE_REG_PERF_EN
    localparam int SUM_W = CNT_W + 3;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] kill_cnt_q,  kill_cnt_d;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({CNT_W{1'b1}})) return '1;
        return s[CNT_W-1:0];
    endfunction

    // Kills are counted from the pre-edge occupancy, i.e. the entries the flush destroys.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (clr) begin
            kill_cnt_d = sat_add(kill_cnt_q, occ);
        end else if (stall && validE) begin
            stall_cnt_d = sat_add(stall_cnt_q, 3'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign stallCnt = stall_cnt_q;
    assign killCnt  = kill_cnt_q;
`else
    assign stallCnt = '0;
    assign killCnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances (DEPTH 1, 2 with 2-bit counters, 3) driven by directed vectors.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         vD [3];
    logic         st [3];
    logic         cl [3];
    logic [15:0]  cD [3];
    logic [127:0] dD [3];
    logic         vE [3];
    logic [15:0]  cE [3];
    logic [127:0] dE [3];
    logic [2:0]   oc [3];
    logic [15:0]  sc0, kc0, sc2, kc2;
    logic [1:0]   sc1, kc1;

    logic [143:0] exq [3][$];
    int n_chk  = 0;
    int n_fail = 0;

`ifdef PIPE_REG_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .stall(st[0]), .clr(cl[0]), .validD(vD[0]), .ctrlD(cD[0]), .dataD(dD[0]),
        .validE(vE[0]), .ctrlE(cE[0]), .dataE(dE[0]), .occ(oc[0]), .stallCnt(sc0), .killCnt(kc0));

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .DEPTH(2), .CNT_W(2)) u_d2 (
        .clk(clk), .rst(rst), .stall(st[1]), .clr(cl[1]), .validD(vD[1]), .ctrlD(cD[1]), .dataD(dD[1]),
        .validE(vE[1]), .ctrlE(cE[1]), .dataE(dE[1]), .occ(oc[1]), .stallCnt(sc1), .killCnt(kc1));

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk(clk), .rst(rst), .stall(st[2]), .clr(cl[2]), .validD(vD[2]), .ctrlD(cD[2]), .dataD(dD[2]),
        .validE(vE[2]), .ctrlE(cE[2]), .dataE(dE[2]), .occ(oc[2]), .stallCnt(sc2), .killCnt(kc2));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // An entry is consumed at E when it is valid and will leave on the coming edge.
    always @(negedge clk) begin
        logic [143:0] e;
        for (int i = 0; i < 3; i++) begin
            if (vE[i] === 1'b1 && st[i] === 1'b0 && cl[i] === 1'b0) begin
                n_chk++;
                if (exq[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL mon%0d_unexpected: got ctrl=%0h data=%0h, required no output", i, cE[i], dE[i]);
                end else begin
                    e = exq[i].pop_front();
                    if ({cE[i], dE[i]} !== e) begin
                        n_fail++;
                        $display("FAIL mon%0d_entry: got ctrl=%0h data=%0h, required ctrl=%0h data=%0h",
                                 i, cE[i], dE[i], e[143:128], e[127:0]);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vD[i] = 1'b0; st[i] = 1'b0; cl[i] = 1'b0; cD[i] = '0; dD[i] = '0;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_validE%0d", i), vE[i], 0);
            chk($sformatf("rst_ctrlE%0d", i), cE[i], 0);
            chk($sformatf("rst_dataE%0d", i), dE[i], 0);
            chk($sformatf("rst_occ%0d", i), oc[i], 0);
        end
        chk("rst_stallCnt1", sc1, 0);
        chk("rst_killCnt1", kc1, 0);
        rst = 1'b0;
        step();

        // T1: DEPTH=1 single entry
        vD[0] = 1'b1; cD[0] = 16'h00A5; dD[0] = 128'h1234;
        exq[0].push_back({16'h00A5, 128'h1234});
        step();
        vD[0] = 1'b0; cD[0] = '0; dD[0] = '0;
        chk("T1_validE", vE[0], 1);
        chk("T1_ctrlE", cE[0], 16'h00A5);
        chk("T1_dataE", dE[0], 128'h1234);
        chk("T1_occ", oc[0], 1);
        step();
        chk("T1_drain_validE", vE[0], 0);
        chk("T1_drain_ctrlE", cE[0], 0);

        // T2: DEPTH=3 stream of three entries
        for (int i = 1; i <= 3; i++) begin
            vD[2] = 1'b1; cD[2] = 16'(i); dD[2] = 128'(i);
            exq[2].push_back({16'(i), 128'(i)});
            step();
            if (i == 2) begin
                chk("T2_latency_validE", vE[2], 0);
                chk("T2_occ_edge2", oc[2], 2);
            end
        end
        vD[2] = 1'b0; cD[2] = '0; dD[2] = '0;
        chk("T2_occ_full", oc[2], 3);
        chk("T2_dataE_edge3", dE[2], 1);
        step();
        chk("T2_dataE_edge4", dE[2], 2);
        chk("T2_occ_edge4", oc[2], 2);
        step();
        chk("T2_dataE_edge5", dE[2], 3);
        chk("T2_ctrlE_edge5", cE[2], 3);
        step();
        chk("T2_empty_validE", vE[2], 0);
        chk("T2_empty_occ", oc[2], 0);

        // T3: DEPTH=2 full then stalled 4 cycles, 2-bit stall counter saturates at 3
        vD[1] = 1'b1; cD[1] = 16'h0001; dD[1] = 128'hA1;
        exq[1].push_back({16'h0001, 128'hA1});
        step();
        cD[1] = 16'h0002; dD[1] = 128'hA2;
        exq[1].push_back({16'h0002, 128'hA2});
        step();
        st[1] = 1'b1; cD[1] = 16'h0007; dD[1] = 128'hDEAD;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("T3_hold_validE", vE[1], 1);
            chk("T3_hold_ctrlE", cE[1], 16'h0001);
            chk("T3_hold_dataE", dE[1], 128'hA1);
            chk("T3_hold_occ", oc[1], 2);
            chk($sformatf("T3_stallCnt_k%0d", k), sc1, PERF ? ((k > 3) ? 3 : k) : 0);
        end
        st[1] = 1'b0; vD[1] = 1'b0; cD[1] = '0; dD[1] = '0;
        step();
        chk("T3_release_dataE", dE[1], 128'hA2);
        step();
        chk("T3_release_empty", oc[1], 0);

        // T4: DEPTH=2, two entries flushed while stall is also high; second flush saturates killCnt
        for (int r = 0; r < 2; r++) begin
            vD[1] = 1'b1; cD[1] = 16'h00B1; dD[1] = 128'hB1;
            step();
            dD[1] = 128'hB2;
            step();
            cl[1] = 1'b1; st[1] = (r == 0);
            chk("T4_occ_before", oc[1], 2);
            step();
            cl[1] = 1'b0; st[1] = 1'b0; vD[1] = 1'b0; cD[1] = '0; dD[1] = '0;
            chk("T4_validE", vE[1], 0);
            chk("T4_ctrlE", cE[1], 0);
            chk("T4_dataE", dE[1], 0);
            chk("T4_occ", oc[1], 0);
            chk($sformatf("T4_killCnt_r%0d", r), kc1, PERF ? ((r == 0) ? 2 : 3) : 0);
        end
        chk("T4_stallCnt_unchanged", sc1, PERF ? 3 : 0);

        // T5: bubbles with a noisy ctrl bundle must surface with ctrl=0
        vD[2] = 1'b0; cD[2] = 16'hFFFF; dD[2] = 128'h5555;
        repeat (3) step();
        chk("T5_validE", vE[2], 0);
        chk("T5_ctrlE", cE[2], 0);
        chk("T5_dataE", dE[2], 128'h5555);
        chk("T5_occ", oc[2], 0);
        cD[2] = '0; dD[2] = '0;

        // T6: async reset between edges while entries are in flight and one stage is stalled
        vD[0] = 1'b1; cD[0] = 16'h0003; dD[0] = 128'h77;
        vD[2] = 1'b1; cD[2] = 16'h00C1; dD[2] = 128'hC1;
        step();
        vD[0] = 1'b0; st[0] = 1'b1; dD[2] = 128'hC2;
        step();
        vD[2] = 1'b0;
        chk("T6_pre_validE0", vE[0], 1);
        chk("T6_pre_stallCnt0", sc0, PERF ? 1 : 0);
        chk("T6_pre_occ2", oc[2], 2);
        #2 rst = 1'b1;
        #1;
        chk("T6_validE0", vE[0], 0);
        chk("T6_ctrlE0", cE[0], 0);
        chk("T6_dataE0", dE[0], 0);
        chk("T6_occ2", oc[2], 0);
        chk("T6_stallCnt0", sc0, 0);
        chk("T6_killCnt1", kc1, 0);
        chk("T6_stallCnt1", sc1, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            vD[i] = 1'b0; st[i] = 1'b0; cl[i] = 1'b0; cD[i] = '0; dD[i] = '0;
        end
        rst = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("end_occ%0d", i), oc[i], 0);
            chk($sformatf("end_queue%0d", i), exq[i].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
